// File: rtl/jtvigil_gfx_arb_if.sv
// jtvigil_gfx_arb_if
// Bundles the two tile-fetcher request ports and the shared SDRAM graphics
// read port of the graphics arbiter.
//   a_cs/a_addr -> a_data/a_ok : scroll layer 1 requester
//   b_cs/b_addr -> b_data/b_ok : scroll layer 2 / char requester
//   rom_addr/rom_cs -> rom_data/rom_ok : SDRAM bank slot
// modport slave  : the arbiter itself
// modport master : the surroundings (video layers plus SDRAM slot)
interface jtvigil_gfx_arb_if #(
  parameter int AW = 17,
  parameter int DW = 32
);
  logic          a_cs;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          a_ok;
  logic          b_cs;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          b_ok;
  logic [AW-1:0] rom_addr;
  logic          rom_cs;
  logic [DW-1:0] rom_data;
  logic          rom_ok;

  modport slave (
    input  a_cs, a_addr, b_cs, b_addr, rom_data, rom_ok,
    output a_data, a_ok, b_data, b_ok, rom_addr, rom_cs
  );

  modport master (
    output a_cs, a_addr, b_cs, b_addr, rom_data, rom_ok,
    input  a_data, a_ok, b_data, b_ok, rom_addr, rom_cs
  );
endinterface

// File: rtl/jtvigil_gfx_arb.sv
// jtvigil_gfx_arb
// Shares one SDRAM graphics read port between two tile-layer fetchers. Each
// requester owns a one-entry cache (address, data, valid), so repeated reads
// of the same address are answered without touching the SDRAM.
// Ports:
//   clk  : video clock, rising edge
//   rst  : asynchronous active-high reset, invalidates both caches
//   bus  : jtvigil_gfx_arb_if.slave (requester A/B ports and SDRAM port)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no transaction; arbitrate pending requesters
// WAIT_A | first cycle of A fetch; rom_ok may still refer to old address
// READ_A | A fetch in flight; capture rom_data on rom_ok
// WAIT_B | first cycle of B fetch; rom_ok ignored
// READ_B | B fetch in flight; capture rom_data on rom_ok
module jtvigil_gfx_arb #(
  parameter int AW = 17,
  parameter int DW = 32
) (
  input  logic clk,
  input  logic rst,
  jtvigil_gfx_arb_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_A = 3'd1,
    READ_A = 3'd2,
    WAIT_B = 3'd3,
    READ_B = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          rom_cs_q, rom_cs_d;
  logic          last_b_q, last_b_d;     // 1: last grant went to B
  logic          a_valid_q, a_valid_d;
  logic          b_valid_q, b_valid_d;
  logic [AW-1:0] a_caddr_q, a_caddr_d;
  logic [AW-1:0] b_caddr_q, b_caddr_d;
  logic [DW-1:0] a_data_q, a_data_d;
  logic [DW-1:0] b_data_q, b_data_d;

  logic a_hit, b_hit, a_pend, b_pend, grant_a, grant_b;

  assign a_hit  = a_valid_q & (a_caddr_q == bus.a_addr);
  assign b_hit  = b_valid_q & (b_caddr_q == bus.b_addr);
  assign a_pend = bus.a_cs & ~a_hit;
  assign b_pend = bus.b_cs & ~b_hit;

  // Round robin on a tie: the requester that did not win last time goes.
  assign grant_a = a_pend & (~b_pend | last_b_q);
  assign grant_b = b_pend & (~a_pend | ~last_b_q);

  assign bus.a_ok     = bus.a_cs & a_hit;
  assign bus.b_ok     = bus.b_cs & b_hit;
  assign bus.a_data   = a_data_q;
  assign bus.b_data   = b_data_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.rom_cs   = rom_cs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      rom_cs_q   <= 1'b0;
      last_b_q   <= 1'b1;
      a_valid_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      a_caddr_q  <= '0;
      b_caddr_q  <= '0;
      a_data_q   <= '0;
      b_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      rom_cs_q   <= rom_cs_d;
      last_b_q   <= last_b_d;
      a_valid_q  <= a_valid_d;
      b_valid_q  <= b_valid_d;
      a_caddr_q  <= a_caddr_d;
      b_caddr_q  <= b_caddr_d;
      a_data_q   <= a_data_d;
      b_data_q   <= b_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    rom_cs_d   = rom_cs_q;
    last_b_d   = last_b_q;
    a_valid_d  = a_valid_q;
    b_valid_d  = b_valid_q;
    a_caddr_d  = a_caddr_q;
    b_caddr_d  = b_caddr_q;
    a_data_d   = a_data_q;
    b_data_d   = b_data_q;
    case (state_q)
      IDLE: begin
        if (grant_a) begin
          rom_addr_d = bus.a_addr;
          rom_cs_d   = 1'b1;
          last_b_d   = 1'b0;
          state_d    = WAIT_A;
        end else if (grant_b) begin
          rom_addr_d = bus.b_addr;
          rom_cs_d   = 1'b1;
          last_b_d   = 1'b1;
          state_d    = WAIT_B;
        end
      end
      WAIT_A: state_d = READ_A;
      WAIT_B: state_d = READ_B;
      READ_A: begin
        if (bus.rom_ok) begin
          a_data_d  = bus.rom_data;
          a_caddr_d = rom_addr_q;
          a_valid_d = 1'b1;
          rom_cs_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      READ_B: begin
        if (bus.rom_ok) begin
          b_data_d  = bus.rom_data;
          b_caddr_d = rom_addr_q;
          b_valid_d = 1'b1;
          rom_cs_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        rom_cs_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

endmodule
